// File: rtl/rf_arb_pkg.sv
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared types and constants for the register-file port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RADDR = 2'd1,
        RWAIT = 2'd2,
        RDONE = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [RADDR_W-1:0] addr;
        logic [XLEN-1:0]    data;
    } wreq_t;

    // x0 is hardwired to zero, so writes to it must never reach the array.
    function automatic logic is_writable(input logic [RADDR_W-1:0] addr);
        return (addr != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Shares the register-file write port between core writeback and
//               debug writes (with starvation guard) and borrows RD1 for reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               core_wvalid,
    input  logic [RADDR_W-1:0] core_waddr,
    input  logic [XLEN-1:0]    core_wdata,
    output logic               core_wready,
    input  logic [RADDR_W-1:0] core_a1,
    output logic               core_rhold,
    input  logic               dbg_valid,
    input  logic               dbg_write,
    input  logic [RADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]    dbg_wdata,
    output logic               dbg_ready,
    output logic               dbg_rvalid,
    output logic [XLEN-1:0]    dbg_rdata,
    output logic [RADDR_W-1:0] rf_a1,
    input  logic [XLEN-1:0]    rf_rd1,
    output logic [RADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]    rf_wb,
    output logic               rf_we
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [RADDR_W-1:0] r_dbg_raddr;
    logic [XLEN-1:0]    r_dbg_rdata;
    logic [3:0]         r_starve_cnt;
    wreq_t              r_wreq;
    logic               r_we;

    logic               w_idle;
    logic               w_dbg_wpend;
    logic               w_dbg_wgrant;
    logic               w_core_wfire;
    logic               w_wr_fire;
    logic               w_rd_accept;
    wreq_t              w_wreq;

    assign w_idle       = (r_state == IDLE);
    assign w_dbg_wpend  = dbg_valid & dbg_write;
    assign w_dbg_wgrant = w_dbg_wpend & w_idle &
                          (~core_wvalid | (r_starve_cnt == c_starve_limit));
    assign core_wready  = ~w_dbg_wgrant;
    assign w_core_wfire = core_wvalid & ~w_dbg_wgrant;
    assign w_wr_fire    = w_dbg_wgrant | w_core_wfire;
    assign w_rd_accept  = w_idle & dbg_valid & ~dbg_write;

    always_comb begin
        w_wreq = '{addr: core_waddr, data: core_wdata};
        if (w_dbg_wgrant) begin
            w_wreq = '{addr: dbg_addr, data: dbg_wdata};
        end
    end

    // Read sequencer: next state and the outputs that depend on it.
    always_comb begin
        w_state_nxt = r_state;
        core_rhold  = 1'b0;
        rf_a1       = core_a1;
        dbg_rvalid  = 1'b0;
        dbg_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                dbg_ready = ~dbg_write | w_dbg_wgrant;
                if (w_rd_accept) begin
                    w_state_nxt = RADDR;
                end
            end
            RADDR: begin
                core_rhold  = 1'b1;
                rf_a1       = r_dbg_raddr;
                w_state_nxt = RWAIT;
            end
            RWAIT: begin
                core_rhold  = 1'b1;
                rf_a1       = r_dbg_raddr;
                w_state_nxt = RDONE;
            end
            RDONE: begin
                dbg_rvalid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dbg_raddr <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_rd_accept) begin
                r_dbg_raddr <= dbg_addr;
            end
            if (r_state == RWAIT) begin
                r_dbg_rdata <= rf_rd1;
            end
        end
    end

    // Counts core wins against a waiting debug write; any gap in the debug
    // request restarts the count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_starve_cnt <= '0;
        end else if (w_dbg_wgrant || !w_dbg_wpend) begin
            r_starve_cnt <= '0;
        end else if (w_core_wfire && (r_starve_cnt < c_starve_limit)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wreq <= '0;
            r_we   <= 1'b0;
        end else begin
            r_we <= w_wr_fire & is_writable(w_wreq.addr);
            if (w_wr_fire) begin
                r_wreq <= w_wreq;
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_a3     = r_wreq.addr;
    assign rf_wb     = r_wreq.data;
    assign dbg_rdata = r_dbg_rdata;

endmodule

`default_nettype wire

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the 32×32 general register file between the core pipeline and the debug/host loader. It arbitrates the single write port (A3/WB/WE) between core writeback and debug writes, with a starvation guard. It also sequences debug reads by borrowing read port 1 (A1/RD1) for a fixed window. It sits between the writeback stage, the debug bridge and the register file, on the core clock domain.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive core writes allowed while a debug write waits; range 1–15.

Ports:
- CLK  in  1  core clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- core_wvalid  in  1  core writeback request.
- core_waddr  in  5  core destination register.
- core_wdata  in  32  core writeback data.
- core_wready  out  1  core write accepted when high with core_wvalid.
- core_a1  in  5  core read-port-1 address.
- core_rhold  out  1  high: RD1 belongs to debug, and the core must stall decode.
- dbg_valid  in  1  debug request.
- dbg_write  in  1  1 = write, 0 = read.
- dbg_addr  in  5  debug register address.
- dbg_wdata  in  32  debug write data.
- dbg_ready  out  1  debug request accepted when high with dbg_valid.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid.
- dbg_rdata  out  32  debug read result, held until the next read.
- rf_a1  out  5  to register file A1.
- rf_rd1  in  32  from register file RD1.
- rf_a3, rf_wb, rf_we  out  5/32/1  to register file write port, registered.

## Operation
- A transfer occurs when valid and ready are both high on a rising CLK edge. Ready may depend combinationally on valid.
- Read FSM states, in order: IDLE → RADDR → RWAIT → RDONE → IDLE.
  - A debug read is accepted only in IDLE.
  - RADDR and RWAIT: rf_a1 = latched dbg_addr, core_rhold = 1.
  - RWAIT: rf_rd1 is captured into dbg_rdata on the clock edge leaving RWAIT.
  - RDONE: dbg_rvalid = 1, core_rhold = 0.
  - All other states: rf_a1 = core_a1 (combinational mux).
- dbg_wgrant = dbg_valid & dbg_write & IDLE & (!core_wvalid | starve_cnt == STARVE_LIMIT).
- core_wready = !dbg_wgrant. Core writes proceed in any FSM state.
- dbg_ready = IDLE & (!dbg_write | dbg_wgrant).
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each core write accepted while a debug write is pending.
  - Clears when a debug write is granted, or when no debug write is pending.
- Writes to address 0 complete the handshake but drive rf_we = 0.
- Coherence between a debug read and a core write to the same address during RADDR/RWAIT is not guaranteed. Software avoids this case.

## Timing
- Write latency: transfer at edge N → rf_we/rf_a3/rf_wb valid from N to N+1, exactly one cycle. Back-to-back writes are supported every cycle.
- Read latency: accept at edge N; RADDR N..N+1; RWAIT N+1..N+2; dbg_rvalid high N+2..N+3. The next debug request can be accepted at edge N+3.
- core_rhold is high for exactly 2 cycles per debug read.
- Simultaneous core and debug write:
  - The core wins unless starve_cnt == STARVE_LIMIT.
  - After STARVE_LIMIT consecutive core wins, the debug write wins one cycle and the core is stalled for that cycle.
- Simultaneous debug read and core write: both proceed.
- Reset (asynchronous, any state):
  - FSM → IDLE, starve_cnt = 0.
  - rf_we = 0, rf_a3 = 0, rf_wb = 0.
  - dbg_rvalid = 0, dbg_rdata = 0.
  - A read in flight is discarded, and no dbg_rvalid is issued after reset.
- Reset values of combinational outputs: core_rhold = 0, rf_a1 = core_a1. core_wready and dbg_ready follow their equations; dbg_ready = 1 for an idle read request.

## Structure
- Package rf_arb_pkg:
  - XLEN = 32, RADDR_W = 5.
  - typedef enum rd_state_t {IDLE, RADDR, RWAIT, RDONE}.
  - typedef struct wreq_t {addr, data}.
- Single module, no sub-module. The starvation counter is inline.

## Test plan
- Core write to x5 = 0xDEADBEEF, no debug traffic → rf_we = 1, rf_a3 = 5, rf_wb = 0xDEADBEEF one cycle later; core_wready stays 1.
- Debug read of x7 (rf_rd1 model returns 0x12345678) → core_rhold high 2 cycles, dbg_rvalid pulses at accept + 2 with dbg_rdata = 0x12345678; core_a1 is routed to rf_a1 before and after the window.
- Core writes every cycle with a debug write to x3 = 0xA5A5A5A5 pending, STARVE_LIMIT = 4 → 4 core writes, then 1 cycle with core_wready = 0 and rf_a3 = 3, then the core resumes.
- Debug write to x0 = 0xFFFFFFFF → dbg_ready = 1, rf_we stays 0.
- Debug read accepted, RST asserted during RWAIT → all outputs at reset values, and no dbg_rvalid appears after release.
- Debug read plus core write to x9 in the same cycle → both accepted, rf_we pulses, and the read completes with normal latency.
